// File: rtl/gray_pkg.sv
// Shared types for the gray-code arbiter: default width, output FSM states, requester id.
package gray_pkg;

    localparam int GRAY_WIDTH_DEF = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/bin2gray_core.sv
// Combinational binary-to-gray converter, WIDTH-parameterised.
module bin2gray_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    always_comb begin
        gray_o[WIDTH-1] = bin_i[WIDTH-1];
        for (int i = 0; i < WIDTH - 1; i++) begin
            gray_o[i] = bin_i[i+1] ^ bin_i[i];
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin arbiter feeding a single-entry gray-code output register.
// Optional per-requester saturating accept counters when GRAY_CONV_STATS_EN is defined.
module gray_conv_arbiter
    import gray_pkg::*;
#(
    parameter int WIDTH   = GRAY_WIDTH_DEF,
    parameter int RR_INIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_bin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_bin,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_gray,
    output logic             out_id,
    input  logic             out_ready
`ifdef GRAY_CONV_STATS_EN
    ,
    output logic [7:0]       stat_cnt0,
    output logic [7:0]       stat_cnt1
`endif
);

    // Handshake: a word moves when valid and ready are both high at a rising edge;
    // ready is combinational and never high for both requesters or during reset.
    localparam req_id_t RR_RST = RR_INIT[0];

    state_e           state_q;
    logic [WIDTH-1:0] gray_q;
    req_id_t          id_q;
    req_id_t          rr_q;

    logic             can_accept;
    logic             accept;
    req_id_t          grant_id;
    logic [WIDTH-1:0] sel_bin;
    logic [WIDTH-1:0] sel_gray;

    always_comb begin
        can_accept = rst_n && ((state_q == EMPTY) || out_ready);
        grant_id   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~rr_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
        accept     = can_accept && (req0_valid || req1_valid);
        req0_ready = accept && (grant_id == 1'b0);
        req1_ready = accept && (grant_id == 1'b1);
        sel_bin    = grant_id ? req1_bin : req0_bin;
    end

    bin2gray_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .bin_i  (sel_bin),
        .gray_o (sel_gray)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            gray_q  <= '0;
            id_q    <= 1'b0;
            rr_q    <= RR_RST;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= FULL;
                        gray_q  <= sel_gray;
                        id_q    <= grant_id;
                        rr_q    <= grant_id;
                    end
                end
                FULL: begin
                    // Drain and refill in the same cycle keeps one word per cycle.
                    if (accept) begin
                        gray_q <= sel_gray;
                        id_q   <= grant_id;
                        rr_q   <= grant_id;
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_gray  = gray_q;
    assign out_id    = id_q;

`ifdef GRAY_CONV_STATS_EN
    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (req0_ready && (cnt0_q != 8'hFF)) begin
            cnt0_d = cnt0_q + 8'd1;
        end
        if (req1_ready && (cnt1_q != 8'hFF)) begin
            cnt1_d = cnt1_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign stat_cnt0 = cnt0_q;
    assign stat_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: directed vectors plus randomized traffic
// against a behavioural model; stat counters checked when GRAY_CONV_STATS_EN is defined.
module tb_gray_conv_arbiter;

    localparam int WIDTH   = 4;
    localparam int RR_INIT = 0;

    logic             clk;
    logic             rst_n;
    logic             req0_valid;
    logic [WIDTH-1:0] req0_bin;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_bin;
    logic             req1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_gray;
    logic             out_id;
    logic             out_ready;
`ifdef GRAY_CONV_STATS_EN
    logic [7:0]       stat_cnt0;
    logic [7:0]       stat_cnt1;
`endif

    gray_conv_arbiter #(
        .WIDTH   (WIDTH),
        .RR_INIT (RR_INIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_bin   (req0_bin),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_bin   (req1_bin),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_gray   (out_gray),
        .out_id     (out_id),
        .out_ready  (out_ready)
`ifdef GRAY_CONV_STATS_EN
        ,
        .stat_cnt0  (stat_cnt0),
        .stat_cnt1  (stat_cnt1)
`endif
    );

    // Clock and initial pin state.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state.
    logic [WIDTH:0] exp_q[$];
    bit             m_full;
    bit             m_rr;
    logic [WIDTH-1:0] m_gray;
    bit             m_id;
    int             m_cnt0;
    int             m_cnt1;
    bit             out_known;
    int             beats;
    int             errors;
    int             checks;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check readies, advance model.
    task automatic step(input bit rn, input bit v0, input logic [WIDTH-1:0] b0,
                        input bit v1, input logic [WIDTH-1:0] b1, input bit ordy);
        bit can;
        bit g1;
        bit e0;
        bit e1;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   beat;
        if (out_known) begin
            check("out_valid", out_valid, m_full);
            check("out_gray", out_gray, m_gray);
            check("out_id", out_id, m_id);
`ifdef GRAY_CONV_STATS_EN
            check("stat_cnt0", stat_cnt0, m_cnt0);
            check("stat_cnt1", stat_cnt1, m_cnt1);
`endif
        end
        rst_n      = rn;
        req0_valid = v0;
        req0_bin   = b0;
        req1_valid = v1;
        req1_bin   = b1;
        out_ready  = ordy;
        #1;
        can = rn && (!m_full || ordy);
        g1  = v1 && (!v0 || !m_rr);
        e1  = can && g1;
        e0  = can && v0 && !g1;
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        if (out_known && rn && m_full && ordy) begin
            if (exp_q.size() == 0) begin
                check("beat_underflow", 1, 0);
            end else begin
                beat = exp_q.pop_front();
                check("beat", {out_id, out_gray}, beat);
                beats++;
            end
        end
        if (!rn) begin
            m_full    = 0;
            m_rr      = RR_INIT[0];
            m_gray    = '0;
            m_id      = 0;
            m_cnt0    = 0;
            m_cnt1    = 0;
            out_known = 1;
            exp_q.delete();
        end else if (e0 || e1) begin
            b      = e1 ? b1 : b0;
            m_gray = b ^ (b >> 1);
            m_id   = e1;
            m_rr   = e1;
            m_full = 1;
            exp_q.push_back({m_id, m_gray});
            if (e0 && m_cnt0 < 255) m_cnt0++;
            if (e1 && m_cnt1 < 255) m_cnt1++;
        end else if (ordy) begin
            m_full = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(0, 0, '0, 0, '0, 0);
        step(0, 0, '0, 0, '0, 0);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        beats      = 0;
        out_known  = 0;
        m_full     = 0;
        m_rr       = RR_INIT[0];
        m_gray     = '0;
        m_id       = 0;
        m_cnt0     = 0;
        m_cnt1     = 0;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req0_bin   = '0;
        req1_valid = 1'b0;
        req1_bin   = '0;
        out_ready  = 1'b0;
        @(negedge clk);

        // Reset state.
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_gray", out_gray, 0);
        check("rst_id", out_id, 0);

        // Single word from requester 0.
        step(1, 1, 4'b1011, 0, '0, 1);
        check("single_valid", out_valid, 1);
        check("single_gray", out_gray, 4'b1110);
        check("single_id", out_id, 0);
        step(1, 0, '0, 0, '0, 1);

        // Both valid: round-robin starts with requester 1.
        do_reset();
        step(1, 1, 4'b0101, 1, 4'b1111, 1);
        check("rr_first_gray", out_gray, 4'b1000);
        check("rr_first_id", out_id, 1);
        step(1, 1, 4'b0101, 1, 4'b1111, 1);
        check("rr_second_gray", out_gray, 4'b0111);
        check("rr_second_id", out_id, 0);
        step(1, 0, '0, 0, '0, 1);

        // Backpressure holds the result and blocks both requesters.
        do_reset();
        step(1, 0, '0, 1, 4'b0010, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, WIDTH'($urandom), 1, WIDTH'($urandom), 0);
            check("hold_valid", out_valid, 1);
            check("hold_gray", out_gray, 4'b0011);
        end
        step(1, 0, '0, 0, '0, 1);
        check("drain_empty", out_valid, 0);

        // Streaming: 8 words alternating requesters, one beat per cycle.
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1, 1, WIDTH'($urandom), 0, '0, 1);
            else            step(1, 0, '0, 1, WIDTH'($urandom), 1);
            if (i > 0) check("stream_valid", out_valid, 1);
        end
        step(1, 0, '0, 0, '0, 1);
        check("stream_beats", beats, 8);

        // Reset while FULL discards the word and restores the RR pointer.
        step(1, 1, 4'b1011, 0, '0, 0);
        step(1, 0, 4'b0110, 0, '0, 0);
        check("pre_rst_gray", out_gray, 4'b1110);
        step(0, 1, 4'b0110, 1, 4'b0001, 1);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_gray", out_gray, 0);
        step(1, 1, 4'b0001, 1, 4'b0010, 1);
        check("post_rst_rr_id", out_id, 1);
        step(1, 0, '0, 0, '0, 1);

`ifdef GRAY_CONV_STATS_EN
        // Saturating counter after 300 accepts from requester 0.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1, 1, WIDTH'($urandom), 0, '0, 1);
        end
        step(1, 0, '0, 0, '0, 1);
        check("stat0_sat", stat_cnt0, 255);
        check("stat1_zero", stat_cnt1, 0);
`endif

        // Randomized traffic with occasional reset.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) != 0),
                 $urandom_range(0, 1) == 1, WIDTH'($urandom),
                 $urandom_range(0, 1) == 1, WIDTH'($urandom),
                 $urandom_range(0, 3) != 0);
        end
        step(1, 0, '0, 0, '0, 1);
        step(1, 0, '0, 0, '0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of binary input and gray output.
REQ-002 Parameter RR_INIT, default 0: requester treated as last-granted after reset (0 or 1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 offers a binary word.
REQ-006 req0_bin  input  WIDTH  requester 0 binary word.
REQ-007 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-008 req1_valid / req1_bin / req1_ready  same as requester 0, for requester 1.
REQ-009 out_valid  output  1  registered gray result available.
REQ-010 out_gray  output  WIDTH  gray code of the accepted word.
REQ-011 out_id  output  1  index of the requester that supplied out_gray.
REQ-012 out_ready  input  1  downstream consumes the result.

Function
REQ-013 Conversion SHALL be g[WIDTH-1]=b[WIDTH-1], g[i]=b[i+1]^b[i] for i<WIDTH-1.
REQ-014 Output register SHALL be a single entry; FSM states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 can_accept SHALL be (state==EMPTY) || out_ready; with can_accept=0, both readies SHALL be 0.
REQ-016 With can_accept=1 and exactly one valid requester, that requester SHALL get ready=1.
REQ-017 With can_accept=1 and both valid, the grant SHALL go to the requester not granted last (round-robin).
REQ-018 Readies SHALL be one-hot or zero, and combinational from valids, state, out_ready, and the RR pointer.
REQ-019 On acceptance, out_gray/out_id SHALL update on the next edge (latency 1 cycle), the state SHALL go to FULL, and the RR pointer SHALL update to the granted index.
REQ-020 FULL with out_ready=1 and no acceptance SHALL go to EMPTY; FULL with out_ready=1 and an acceptance SHALL stay FULL with new data (back-to-back, 1 word/cycle).
REQ-021 FULL with out_ready=0 SHALL hold out_gray/out_id stable.
REQ-022 The RR pointer SHALL change only on an acceptance; an idle cycle leaves it unchanged.
REQ-023 A requester SHALL NOT be accepted twice for one valid assertion; each accepted word produces exactly one output beat.

Reset
REQ-024 When rst_n=0 at an edge: state SHALL be EMPTY, out_valid=0, out_gray=0, out_id=0, RR pointer=RR_INIT, and the stats counter (if present) =0.
REQ-025 Reset while FULL SHALL discard the held result with no output beat, and readies SHALL be 0 while rst_n=0.

Configuration
REQ-026 Macro GRAY_CONV_STATS_EN defined: the module SHALL add ports stat_cnt0 and stat_cnt1 (output, 8 bits each), counting acceptances per requester and saturating at 255.
REQ-027 Macro GRAY_CONV_STATS_EN undefined: the stat ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package gray_pkg SHALL hold the default WIDTH constant, the state enum (EMPTY, FULL), and the requester-id typedef.
REQ-029 Conversion SHALL live in sub-module bin2gray_core (combinational, WIDTH-parameterised), instantiated once on the muxed granted word.

Verification
REQ-030 Reset, then req0_valid=1 with req0_bin=4'b1011 and out_ready=1 -> req0_ready=1; next cycle out_valid=1, out_gray=4'b1110, out_id=0.
REQ-031 Both valid (req0=4'b0101, req1=4'b1111) held for 2 cycles, out_ready=1, RR_INIT=0 -> first beat out_gray=4'b1000 with id=1; second beat 4'b0111 with id=0.
REQ-032 Accept req1=4'b0010 with out_ready=0 for 3 cycles -> out_valid=1, out_gray=4'b0011 stable, both readies 0; out_ready=1 -> EMPTY next cycle.
REQ-033 Streaming: alternate 8 words with out_ready=1 -> 8 beats on consecutive cycles, no gaps, order matches grants.
REQ-034 rst_n=0 while FULL with out_gray=4'b1110 -> next cycle out_valid=0, out_gray=0, and the RR pointer equals RR_INIT.
REQ-035 With GRAY_CONV_STATS_EN defined: 300 accepts from req0 -> stat_cnt0=255, stat_cnt1=0.
